// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle between a control unit and alu_seq.
//
// Handshake: a request is accepted on a rising clock edge where start=1 and
// busy=0 (busy acts as an inverted ready). op/op1/op2 are sampled only on
// that edge. done is a one-cycle pulse that marks ops/zf/dz (and rem, when
// built) as freshly updated. These outputs hold their value until the next
// done. A start seen while busy=1 is dropped, not queued.
//
// Signals:
//   start  request strobe (master -> slave)
//   op     3-bit opcode
//   op1    operand A
//   op2    operand B
//   busy   iterative MUL/DIV in progress
//   done   completion pulse
//   ops    registered result
//   zf     ops == 0
//   dz     last completed op was a divide by zero
//   rem    remainder (only with ALU_REM_EN defined)
//
// Optional feature macro: ALU_REM_EN.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] ops;
    logic             zf;
    logic             dz;
`ifdef ALU_REM_EN
    logic [WIDTH-1:0] rem;

    modport master (
        output start, op, op1, op2,
        input  busy, done, ops, zf, dz, rem
    );

    modport slave (
        input  start, op, op1, op2,
        output busy, done, ops, zf, dz, rem
    );
`else
    modport master (
        output start, op, op1, op2,
        input  busy, done, ops, zf, dz
    );

    modport slave (
        input  start, op, op1, op2,
        output busy, done, ops, zf, dz
    );
`endif
endinterface

// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with single-cycle logic/arith/compare ops and
// iterative WIDTH-cycle shift-add multiply and restoring divide.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        alu_seq_if.slave (start/op/op1/op2 in; busy/done/ops/zf/dz out,
//              plus rem when ALU_REM_EN is defined)
//   state_dbg  current FSM state (0 IDLE, 1 MUL_RUN, 2 DIV_RUN)
//
// Opcodes: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT (unsigned),
//          101 DIV, 110 ZERO, 111 MUL.
//
// Optional feature macro: ALU_REM_EN adds a remainder output register.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus,
    output logic [1:0] state_dbg
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_SLT  = 3'b100;
    localparam logic [2:0] OP_DIV  = 3'b101;
    localparam logic [2:0] OP_ZERO = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2
    } state_t;

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    // MUL: acc = partial product, b = multiplicand (shifts left),
    //      q = multiplier (shifts right).
    // DIV: acc = partial remainder, b = divisor, q = dividend bits shifting
    //      out the top while quotient bits shift in at the bottom.
    logic [WIDTH-1:0] acc_q, acc_n;
    logic [WIDTH-1:0] b_q, b_n;
    logic [WIDTH-1:0] q_q, q_n;
    logic [WIDTH-1:0] ops_q, ops_n;
    logic             zf_q, zf_n;
    logic             dz_q, dz_n;
    logic             done_q, done_n;
`ifdef ALU_REM_EN
    logic [WIDTH-1:0] rem_q, rem_n;
`endif

    // Single-cycle result; DIV only reaches this path when op2 == 0.
    logic [WIDTH-1:0] fast_res;

    always_comb begin
        fast_res = '0;
        case (bus.op)
            OP_AND:  fast_res = bus.op1 & bus.op2;
            OP_OR:   fast_res = bus.op1 | bus.op2;
            OP_ADD:  fast_res = bus.op1 + bus.op2;
            OP_SUB:  fast_res = bus.op1 - bus.op2;
            OP_SLT:  fast_res = WIDTH'(bus.op1 < bus.op2);
            OP_DIV:  fast_res = '1;
            default: fast_res = '0;
        endcase
    end

    // One iteration of each iterative algorithm.
    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH:0]   div_trial;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] div_quo;

    always_comb begin
        mul_acc   = acc_q + (q_q[0] ? b_q : '0);
        div_trial = {acc_q, q_q[WIDTH-1]};
        div_ge    = (div_trial >= {1'b0, b_q});
        div_rem   = div_ge ? WIDTH'(div_trial - {1'b0, b_q}) : div_trial[WIDTH-1:0];
        div_quo   = {q_q[WIDTH-2:0], div_ge};
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        acc_n   = acc_q;
        b_n     = b_q;
        q_n     = q_q;
        ops_n   = ops_q;
        zf_n    = zf_q;
        dz_n    = dz_q;
        done_n  = 1'b0;
`ifdef ALU_REM_EN
        rem_n   = rem_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.op == OP_MUL) begin
                        state_n = MUL_RUN;
                        cnt_n   = CNT_W'(WIDTH);
                        acc_n   = '0;
                        b_n     = bus.op2;
                        q_n     = bus.op1;
                    end else if (bus.op == OP_DIV && bus.op2 != '0) begin
                        state_n = DIV_RUN;
                        cnt_n   = CNT_W'(WIDTH);
                        acc_n   = '0;
                        b_n     = bus.op2;
                        q_n     = bus.op1;
                    end else begin
                        ops_n  = fast_res;
                        zf_n   = (fast_res == '0);
                        dz_n   = (bus.op == OP_DIV);
                        done_n = 1'b1;
`ifdef ALU_REM_EN
                        rem_n  = (bus.op == OP_DIV) ? bus.op1 : '0;
`endif
                    end
                end
            end
            MUL_RUN: begin
                acc_n = mul_acc;
                b_n   = {b_q[WIDTH-2:0], 1'b0};
                q_n   = {1'b0, q_q[WIDTH-1:1]};
                cnt_n = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_n = IDLE;
                    ops_n   = mul_acc;
                    zf_n    = (mul_acc == '0);
                    dz_n    = 1'b0;
                    done_n  = 1'b1;
`ifdef ALU_REM_EN
                    rem_n   = '0;
`endif
                end
            end
            DIV_RUN: begin
                acc_n = div_rem;
                q_n   = div_quo;
                cnt_n = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_n = IDLE;
                    ops_n   = div_quo;
                    zf_n    = (div_quo == '0);
                    dz_n    = 1'b0;
                    done_n  = 1'b1;
`ifdef ALU_REM_EN
                    rem_n   = div_rem;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            q_q     <= '0;
            ops_q   <= '0;
            zf_q    <= 1'b1;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            acc_q   <= acc_n;
            b_q     <= b_n;
            q_q     <= q_n;
            ops_q   <= ops_n;
            zf_q    <= zf_n;
            dz_q    <= dz_n;
            done_q  <= done_n;
        end
    end

`ifdef ALU_REM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
        end else begin
            rem_q <= rem_n;
        end
    end

    assign bus.rem = rem_q;
`endif

    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = done_q;
    assign bus.ops   = ops_q;
    assign bus.zf    = zf_q;
    assign bus.dz    = dz_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed-vector bench for alu_seq at WIDTH=32 and WIDTH=8.
module tb_alu_seq;
    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_SLT  = 3'b100;
    localparam logic [2:0] OP_DIV  = 3'b101;
    localparam logic [2:0] OP_ZERO = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    logic       clk;
    logic       rst_n;
    logic [1:0] state_dbg32;
    logic [1:0] state_dbg8;
    int         checks;
    int         failures;

    alu_seq_if #(.WIDTH(32)) bus32 ();
    alu_seq_if #(.WIDTH(8))  bus8 ();

    alu_seq #(.WIDTH(32)) u_dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus32),
        .state_dbg (state_dbg32)
    );

    alu_seq #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus8),
        .state_dbg (state_dbg8)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic issue32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus32.start = 1'b1;
        bus32.op    = op;
        bus32.op1   = a;
        bus32.op2   = b;
        @(negedge clk);
        bus32.start = 1'b0;
    endtask

    task automatic issue8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.op    = op;
        bus8.op1   = a;
        bus8.op2   = b;
        @(negedge clk);
        bus8.start = 1'b0;
    endtask

    // Runs an iterative op on the 32-bit DUT, scrambling operands and
    // pulsing a stray START mid-run; collects DONE count/cycle/result.
    task automatic run_iter32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              output int done_cnt, output int done_at,
                              output logic [31:0] got_ops, output int busy_bad);
        done_cnt = 0;
        done_at  = 0;
        got_ops  = '0;
        busy_bad = 0;
        issue32(op, a, b);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 5) begin
                bus32.op1 = $urandom_range(32'hFFFF, 1);
                bus32.op2 = $urandom_range(32'hFFFF, 1);
            end
            if (n == 10) begin
                bus32.start = 1'b1;
                bus32.op    = OP_ADD;
            end
            if (n == 11) bus32.start = 1'b0;
            if (bus32.done === 1'b1) begin
                done_cnt++;
                done_at = n;
                got_ops = bus32.ops;
            end
            if (n < 32 && bus32.busy !== 1'b1) busy_bad++;
        end
    endtask

    task automatic run_iter8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                             output int done_cnt, output int done_at, output logic [7:0] got_ops);
        done_cnt = 0;
        done_at  = 0;
        got_ops  = '0;
        issue8(op, a, b);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bus8.done === 1'b1) begin
                done_cnt++;
                done_at = n;
                got_ops = bus8.ops;
            end
        end
    endtask

    task automatic test_reset;
        checks++; if (bus32.ops !== 32'h0) begin failures++; $display("FAIL reset_ops got=%h exp=%h", bus32.ops, 32'h0); end
        checks++; if (bus32.zf !== 1'b1) begin failures++; $display("FAIL reset_zf got=%b exp=1", bus32.zf); end
        checks++; if (bus32.busy !== 1'b0 || bus32.done !== 1'b0 || bus32.dz !== 1'b0) begin
            failures++; $display("FAIL reset_flags busy=%b done=%b dz=%b exp=000", bus32.busy, bus32.done, bus32.dz); end
`ifdef ALU_REM_EN
        checks++; if (bus32.rem !== 32'h0) begin failures++; $display("FAIL reset_rem got=%h exp=0", bus32.rem); end
`endif
    endtask

    task automatic test_reset_mid_mul;
        issue32(OP_ADD, 32'd1, 32'd2);
        checks++; if (bus32.ops !== 32'd3) begin failures++; $display("FAIL pre_add got=%h exp=%h", bus32.ops, 32'd3); end
        issue32(OP_MUL, 32'h1234, 32'h5678);
        checks++; if (bus32.busy !== 1'b1 || state_dbg32 !== 2'd1) begin
            failures++; $display("FAIL mul_start busy=%b state=%0d exp busy=1 state=1", bus32.busy, state_dbg32); end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus32.busy !== 1'b0 || bus32.done !== 1'b0 || state_dbg32 !== 2'd0) begin
            failures++; $display("FAIL async_rst_ctl busy=%b done=%b state=%0d exp 0/0/0", bus32.busy, bus32.done, state_dbg32); end
        checks++; if (bus32.ops !== 32'h0 || bus32.zf !== 1'b1) begin
            failures++; $display("FAIL async_rst_ops ops=%h zf=%b exp ops=0 zf=1", bus32.ops, bus32.zf); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        issue32(OP_ADD, 32'd5, 32'd7);
        checks++; if (bus32.done !== 1'b1) begin failures++; $display("FAIL add_done got=%b exp=1", bus32.done); end
        checks++; if (bus32.ops !== 32'd12 || bus32.zf !== 1'b0) begin
            failures++; $display("FAIL add_res ops=%h zf=%b exp ops=c zf=0", bus32.ops, bus32.zf); end
        checks++; if (bus32.busy !== 1'b0) begin failures++; $display("FAIL add_busy got=%b exp=0", bus32.busy); end
        @(negedge clk);
        checks++; if (bus32.done !== 1'b0 || bus32.ops !== 32'd12) begin
            failures++; $display("FAIL add_hold done=%b ops=%h exp done=0 ops=c", bus32.done, bus32.ops); end
        issue32(OP_ADD, 32'hFFFF_FFFF, 32'd1);
        checks++; if (bus32.ops !== 32'h0 || bus32.zf !== 1'b1) begin
            failures++; $display("FAIL add_wrap ops=%h zf=%b exp ops=0 zf=1", bus32.ops, bus32.zf); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        bus32.start = 1'b1; bus32.op = OP_SUB; bus32.op1 = 32'h5; bus32.op2 = 32'h5;
        @(negedge clk);
        checks++; if (bus32.done !== 1'b1 || bus32.ops !== 32'h0 || bus32.zf !== 1'b1) begin
            failures++; $display("FAIL b2b_sub done=%b ops=%h zf=%b exp 1/0/1", bus32.done, bus32.ops, bus32.zf); end
        bus32.op = OP_SLT; bus32.op1 = 32'd3; bus32.op2 = 32'd9;
        @(negedge clk);
        bus32.start = 1'b0;
        checks++; if (bus32.done !== 1'b1 || bus32.ops !== 32'h1 || bus32.zf !== 1'b0) begin
            failures++; $display("FAIL b2b_slt done=%b ops=%h zf=%b exp 1/1/0", bus32.done, bus32.ops, bus32.zf); end
        issue32(OP_SLT, 32'd9, 32'd3);
        checks++; if (bus32.ops !== 32'h0) begin failures++; $display("FAIL slt_false got=%h exp=0", bus32.ops); end
        issue32(OP_SUB, 32'd0, 32'd1);
        checks++; if (bus32.ops !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sub_wrap got=%h exp=ffffffff", bus32.ops); end
    endtask

    task automatic test_mul;
        int d_cnt, d_at, b_bad;
        logic [31:0] r;
        run_iter32(OP_MUL, 32'hFFFF_FFFF, 32'd2, d_cnt, d_at, r, b_bad);
        checks++; if (d_cnt !== 1) begin failures++; $display("FAIL mul_done_count got=%0d exp=1", d_cnt); end
        checks++; if (d_at !== 32) begin failures++; $display("FAIL mul_latency got=%0d exp=32", d_at); end
        checks++; if (r !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mul_res got=%h exp=fffffffe", r); end
        checks++; if (b_bad !== 0) begin failures++; $display("FAIL mul_busy got=%0d drops exp=0", b_bad); end
    endtask

    task automatic test_div;
        int d_cnt, d_at, b_bad;
        logic [31:0] r;
        run_iter32(OP_DIV, 32'd100, 32'd7, d_cnt, d_at, r, b_bad);
        checks++; if (d_cnt !== 1 || d_at !== 32) begin
            failures++; $display("FAIL div_timing count=%0d at=%0d exp 1/32", d_cnt, d_at); end
        checks++; if (r !== 32'd14 || bus32.dz !== 1'b0) begin
            failures++; $display("FAIL div_res ops=%h dz=%b exp ops=e dz=0", r, bus32.dz); end
`ifdef ALU_REM_EN
        checks++; if (bus32.rem !== 32'd2) begin failures++; $display("FAIL div_rem got=%h exp=2", bus32.rem); end
`endif
    endtask

    task automatic test_div_zero;
        issue32(OP_DIV, 32'd9, 32'd0);
        checks++; if (bus32.done !== 1'b1 || bus32.busy !== 1'b0) begin
            failures++; $display("FAIL dz_timing done=%b busy=%b exp 1/0", bus32.done, bus32.busy); end
        checks++; if (bus32.ops !== 32'hFFFF_FFFF || bus32.dz !== 1'b1 || bus32.zf !== 1'b0) begin
            failures++; $display("FAIL dz_res ops=%h dz=%b zf=%b exp ffffffff/1/0", bus32.ops, bus32.dz, bus32.zf); end
`ifdef ALU_REM_EN
        checks++; if (bus32.rem !== 32'd9) begin failures++; $display("FAIL dz_rem got=%h exp=9", bus32.rem); end
`endif
        issue32(OP_AND, 32'hF0, 32'h3C);
        checks++; if (bus32.ops !== 32'h30 || bus32.dz !== 1'b0) begin
            failures++; $display("FAIL and_after_dz ops=%h dz=%b exp 30/0", bus32.ops, bus32.dz); end
`ifdef ALU_REM_EN
        checks++; if (bus32.rem !== 32'd0) begin failures++; $display("FAIL and_rem got=%h exp=0", bus32.rem); end
`endif
    endtask

    task automatic test_or_zero;
        issue32(OP_OR, 32'hA000_0000, 32'h0000_0005);
        checks++; if (bus32.ops !== 32'hA000_0005) begin failures++; $display("FAIL or_res got=%h exp=a0000005", bus32.ops); end
        issue32(OP_ZERO, 32'h1234, 32'h5678);
        checks++; if (bus32.done !== 1'b1 || bus32.ops !== 32'h0 || bus32.zf !== 1'b1) begin
            failures++; $display("FAIL zero_op done=%b ops=%h zf=%b exp 1/0/1", bus32.done, bus32.ops, bus32.zf); end
    endtask

    task automatic test_width8;
        int d_cnt, d_at;
        logic [7:0] r;
        issue8(OP_OR, 8'h0F, 8'h30);
        checks++; if (bus8.ops !== 8'h3F || bus8.zf !== 1'b0) begin
            failures++; $display("FAIL w8_or ops=%h zf=%b exp 3f/0", bus8.ops, bus8.zf); end
        run_iter8(OP_MUL, 8'h10, 8'h10, d_cnt, d_at, r);
        checks++; if (d_cnt !== 1 || d_at !== 8) begin
            failures++; $display("FAIL w8_mul_timing count=%0d at=%0d exp 1/8", d_cnt, d_at); end
        checks++; if (r !== 8'h00 || bus8.zf !== 1'b1) begin
            failures++; $display("FAIL w8_mul_res ops=%h zf=%b exp 00/1", r, bus8.zf); end
        run_iter8(OP_DIV, 8'hFF, 8'h01, d_cnt, d_at, r);
        checks++; if (d_cnt !== 1 || d_at !== 8) begin
            failures++; $display("FAIL w8_div_timing count=%0d at=%0d exp 1/8", d_cnt, d_at); end
        checks++; if (r !== 8'hFF || bus8.zf !== 1'b0 || bus8.dz !== 1'b0) begin
            failures++; $display("FAIL w8_div_res ops=%h zf=%b dz=%b exp ff/0/0", r, bus8.zf, bus8.dz); end
        run_iter8(OP_MUL, 8'h0D, 8'h0B, d_cnt, d_at, r);
        checks++; if (r !== 8'h8F) begin failures++; $display("FAIL w8_mul_13x11 got=%h exp=8f", r); end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        bus32.start = 1'b0; bus32.op = OP_AND; bus32.op1 = '0; bus32.op2 = '0;
        bus8.start  = 1'b0; bus8.op  = OP_AND; bus8.op1  = '0; bus8.op2  = '0;
        repeat (3) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        test_reset_mid_mul;
        test_add;
        test_back_to_back;
        test_mul;
        test_div;
        test_div_zero;
        test_or_zero;
        test_width8;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, clocked successor to the datapath's combinational ALU, with the same 3-bit opcode map.
- Logic, add, sub and compare complete in one cycle.
- MUL (shift-add) and DIV (restoring) are iterative over WIDTH cycles behind a START/BUSY/DONE handshake.
- The result register and flags hold stable between operations, so the control unit can stall on BUSY and sample OPS/ZF on DONE.

Parameters:
WIDTH, 32, operand/result width in bits (>=4).
CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
CLK  input  1  clock, rising edge.
RST_N  input  1  reset, asynchronous, active-low.
START  input  1  request; sampled only when BUSY=0.
OP  input  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 101 DIV, 110 ZERO, 111 MUL.
OP1  input  WIDTH  operand A, captured at the accepting edge.
OP2  input  WIDTH  operand B, captured at the accepting edge.
BUSY  output  1  iterative operation in progress.
DONE  output  1  one-cycle pulse: OPS/ZF/DZ updated.
OPS  output  WIDTH  registered result.
ZF  output  1  1 when OPS==0; updated together with OPS.
DZ  output  1  divide-by-zero flag of the last completed op.

Behaviour:
- Reset (RST_N=0, async, any state, including mid-iteration):
  - State IDLE, counter 0.
  - OPS=0, ZF=1, DZ=0, DONE=0, BUSY=0. Partial MUL/DIV is discarded.
- States: IDLE, MUL_RUN, DIV_RUN.
- Accept: edge k with START=1 and BUSY=0. Operands and OP are captured there; later operand changes have no effect.
- Fast ops (000,001,010,011,100,110, and 101 with OP2==0):
  - Result written to OPS at edge k.
  - DONE=1 for the cycle after k. BUSY stays 0.
- ADD/SUB: modulo 2^WIDTH, carry/borrow dropped.
- SLT: unsigned; OPS = 1 if OP1<OP2, else 0.
- ZERO: OPS=0.
- DIV by zero:
  - OPS = all ones, DZ=1. Fast path, latency 1.
  - DZ is cleared on every other completion.
- MUL (111):
  - Edge k enters MUL_RUN, BUSY=1, counter=WIDTH.
  - Each edge: add multiplicand if multiplier LSB=1, shift, counter-1.
  - At the edge where counter goes 1->0: OPS = low WIDTH bits of the product, state IDLE, BUSY=0, DONE=1 next cycle.
  - Latency WIDTH edges after k.
- DIV (101, OP2!=0):
  - Unsigned restoring divide, one quotient bit per edge, same counter/latency rules as MUL.
  - OPS = quotient.
- ZF = (next OPS == 0), registered with OPS. It never changes without a DONE.
- START while BUSY=1: ignored, no queueing.
- START in a DONE cycle with BUSY=0: accepted; back-to-back fast ops give DONE every cycle.
- OP 110 with START: completes normally (DONE pulses, OPS=0, ZF=1).

Optional Feature:
ALU_REM_EN.
- Defined:
  - Adds output REM [WIDTH-1:0], reset 0, updated only on DONE.
  - DIV: REM = remainder. DIV by zero: REM = OP1.
  - All other ops: REM = 0.
- Undefined:
  - No REM port; remainder register is not built.
  - Behaviour otherwise identical.

Test Plan:
1. WIDTH=32: reset low mid-MUL (3 cycles in) -> BUSY=0, DONE=0, OPS=0, ZF=1 immediately, without waiting for CLK; after release, ADD 5+7 -> DONE next cycle, OPS=12, ZF=0.
2. SUB 0x5-0x5 then SLT 3<9 back-to-back -> DONE in two consecutive cycles; OPS=0,ZF=1 then OPS=1,ZF=0.
3. MUL 0xFFFF_FFFF*2 -> BUSY for 32 cycles, OPS=0xFFFF_FFFE on DONE; START pulsed mid-run is ignored (exactly one DONE).
4. DIV 100/7 -> OPS=14 after 32 cycles, DZ=0; with ALU_REM_EN, REM=2.
5. DIV 9/0 -> DONE after 1 cycle, OPS=0xFFFF_FFFF, DZ=1; following AND -> DZ=0.
6. WIDTH=8: MUL 0x10*0x10 -> OPS=0x00, ZF=1 after 8 cycles; DIV 0xFF/0x01 -> OPS=0xFF.
